// File: rtl/int_to_fp_norm_ctrl_if.sv
// rtl/int_to_fp_norm_ctrl_if.sv - operand and result handshake bundle for the int-to-float normaliser
interface int_to_fp_norm_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic        out_zero;
  logic [7:0]  out_exp;
  logic [31:0] out_mant;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_exp, out_mant
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_exp, out_mant
  );
endinterface

// File: rtl/int_to_fp_norm_ctrl.sv
// rtl/int_to_fp_norm_ctrl.sv - sign/magnitude/lzc front end and sideband alignment around an external 2-stage shifter
module int_to_fp_norm_ctrl #(
  parameter int SIGNED = 1,
  parameter int BIAS   = 127
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  input  logic                   flush,
  int_to_fp_norm_ctrl_if.slave   bus,
  output logic                   shf_aclr,
  output logic                   shf_clk_en,
  output logic [31:0]            shf_data,
  output logic [4:0]             shf_distance,
  input  logic [31:0]            shf_result,
  output logic [1:0]             occupancy
);

  logic        w_sign;
  logic [31:0] w_mag;
  logic        w_zero;
  logic [4:0]  w_lzc;
  logic [7:0]  w_exp;
  logic        w_stall;
  logic        w_advance;
  logic        w_accept;

  logic        r_v0, r_v1, r_v2;
  logic [31:0] r_mag;
  logic [4:0]  r_lzc;
  logic        r_sign0, r_sign1, r_sign2;
  logic        r_zero0, r_zero1, r_zero2;
  logic [7:0]  r_exp0, r_exp1, r_exp2;

  assign w_sign = (SIGNED != 0) && bus.in_data[31];
  // Two's complement negate mod 2^32, so 0x80000000 keeps its own magnitude.
  assign w_mag  = w_sign ? (32'd0 - bus.in_data) : bus.in_data;
  assign w_zero = (w_mag == 32'd0);

  // Highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) w_lzc = 5'(31 - i);
    end
  end

  assign w_exp = w_zero ? 8'd0 : 8'(BIAS + 31 - int'(w_lzc));

  assign w_stall    = r_v2 & ~bus.out_ready;
  assign w_advance  = ~w_stall;
  assign w_accept   = bus.in_valid & bus.in_ready;

  assign bus.in_ready = w_advance & ~flush;
  assign shf_clk_en   = w_advance;
  assign shf_aclr     = ~aclr_n;
  assign shf_data     = r_mag;
  assign shf_distance = r_lzc;

  assign bus.out_valid = r_v2;
  assign bus.out_sign  = r_sign2;
  assign bus.out_zero  = r_zero2;
  assign bus.out_exp   = r_exp2;
  assign bus.out_mant  = shf_result;

  assign occupancy = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_v2};

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_mag   <= 32'd0;
      r_lzc   <= 5'd0;
      r_sign0 <= 1'b0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_zero0 <= 1'b0;
      r_zero1 <= 1'b0;
      r_zero2 <= 1'b0;
      r_exp0  <= 8'd0;
      r_exp1  <= 8'd0;
      r_exp2  <= 8'd0;
    end else if (flush) begin
      // Shifter data is left alone; cleared valids mask whatever it holds.
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (w_advance) begin
      r_v0    <= w_accept;
      r_v1    <= r_v0;
      r_v2    <= r_v1;
      r_sign1 <= r_sign0;
      r_zero1 <= r_zero0;
      r_exp1  <= r_exp0;
      r_sign2 <= r_sign1;
      r_zero2 <= r_zero1;
      r_exp2  <= r_exp1;
      if (w_accept) begin
        r_mag   <= w_mag;
        r_lzc   <= w_lzc;
        r_sign0 <= w_sign;
        r_zero0 <= w_zero;
        r_exp0  <= w_exp;
      end
    end
  end

endmodule

// File: tb/tb_int_to_fp_norm_ctrl.sv
// tb/tb_int_to_fp_norm_ctrl.sv - directed and random bench for both SIGNED settings with a shifter model and scoreboard
module tb_int_to_fp_norm_ctrl;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;

  always #5 clock = ~clock;

  int_to_fp_norm_ctrl_if bus_s ();
  int_to_fp_norm_ctrl_if bus_u ();

  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.out_ready = out_ready;
  assign bus_u.in_valid  = in_valid;
  assign bus_u.in_data   = in_data;
  assign bus_u.out_ready = out_ready;

  logic        shf_aclr_s, shf_en_s, shf_aclr_u, shf_en_u;
  logic [31:0] shf_data_s, shf_res_s, shf_data_u, shf_res_u;
  logic [4:0]  shf_dist_s, shf_dist_u;
  logic [1:0]  occ_s, occ_u;
  logic [31:0] sr1_s, sr2_s, sr1_u, sr2_u;

  int_to_fp_norm_ctrl #(.SIGNED(1), .BIAS(127)) u_dut_s (
    .clock(clock), .aclr_n(aclr_n), .flush(flush), .bus(bus_s),
    .shf_aclr(shf_aclr_s), .shf_clk_en(shf_en_s), .shf_data(shf_data_s),
    .shf_distance(shf_dist_s), .shf_result(shf_res_s), .occupancy(occ_s)
  );

  int_to_fp_norm_ctrl #(.SIGNED(0), .BIAS(127)) u_dut_u (
    .clock(clock), .aclr_n(aclr_n), .flush(flush), .bus(bus_u),
    .shf_aclr(shf_aclr_u), .shf_clk_en(shf_en_u), .shf_data(shf_data_u),
    .shf_distance(shf_dist_u), .shf_result(shf_res_u), .occupancy(occ_u)
  );

  always_ff @(posedge clock or posedge shf_aclr_s) begin
    if (shf_aclr_s) begin
      sr1_s <= 32'd0;
      sr2_s <= 32'd0;
    end else if (shf_en_s) begin
      sr1_s <= shf_data_s << shf_dist_s;
      sr2_s <= sr1_s;
    end
  end
  assign shf_res_s = sr2_s;

  always_ff @(posedge clock or posedge shf_aclr_u) begin
    if (shf_aclr_u) begin
      sr1_u <= 32'd0;
      sr2_u <= 32'd0;
    end else if (shf_en_u) begin
      sr1_u <= shf_data_u << shf_dist_u;
      sr2_u <= sr1_u;
    end
  end
  assign shf_res_u = sr2_u;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [41:0] ref_model(input logic [31:0] x, input bit sgn);
    logic        s;
    logic [31:0] m;
    int          lz;
    s  = sgn & x[31];
    m  = s ? (32'd0 - x) : x;
    lz = 0;
    if (m == 32'd0) return {s, 1'b1, 8'd0, 32'd0};
    while (!m[31]) begin
      m = m << 1;
      lz++;
    end
    return {s, 1'b0, 8'(127 + 31 - lz), m};
  endfunction

  logic [31:0] q_s[$];
  logic [31:0] q_u[$];

  task automatic sb_step(input bit sgn, input logic [1:0] occ, input logic ir,
                         input logic ov, input logic [41:0] obs);
    int          sz;
    logic [31:0] x;
    if (!aclr_n) begin
      if (sgn) q_s.delete(); else q_u.delete();
      return;
    end
    sz = sgn ? q_s.size() : q_u.size();
    check(sgn ? "occ_s" : "occ_u", 64'(occ), 64'(sz));
    if (ov && out_ready) begin
      check(sgn ? "sb_item_s" : "sb_item_u", 64'(sz != 0), 64'd1);
      if (sz != 0) begin
        x = sgn ? q_s.pop_front() : q_u.pop_front();
        check(sgn ? "sb_res_s" : "sb_res_u", 64'(obs), 64'(ref_model(x, sgn)));
      end
    end
    if (flush) begin
      if (sgn) q_s.delete(); else q_u.delete();
    end else if (in_valid && ir) begin
      if (sgn) begin
        q_s.push_back(in_data);
        n_acc++;
      end else begin
        q_u.push_back(in_data);
      end
    end
  endtask

  always @(negedge clock) begin
    sb_step(1'b1, occ_s, bus_s.in_ready, bus_s.out_valid,
            {bus_s.out_sign, bus_s.out_zero, bus_s.out_exp, bus_s.out_mant});
    sb_step(1'b0, occ_u, bus_u.in_ready, bus_u.out_valid,
            {bus_u.out_sign, bus_u.out_zero, bus_u.out_exp, bus_u.out_mant});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] t2_in[4]  = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF};
  logic [41:0] t2_exp[4] = '{{1'b1, 1'b0, 8'd127, 32'h80000000},
                             {1'b1, 1'b0, 8'd158, 32'h80000000},
                             {1'b0, 1'b1, 8'd0,   32'h00000000},
                             {1'b0, 1'b0, 8'd157, 32'hFFFFFFFE}};
  logic [31:0] t3_in[3]  = '{32'h10, 32'h20, 32'h30};
  logic [31:0] rnd;
  int          cyc;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(bus_s.out_valid), 64'd0);
    check("rst_occ", 64'(occ_s), 64'd0);
    check("rst_shf_aclr", 64'(shf_aclr_s), 64'd1);
    check("rst_shf_dist", 64'(shf_dist_s), 64'd0);
    check("rst_shf_data", 64'(shf_data_s), 64'd0);
    check("rst_in_ready", 64'(bus_s.in_ready), 64'd1);
    aclr_n    = 1'b1;
    out_ready = 1'b1;

    in_valid = 1'b1;
    in_data  = 32'h1;
    step();
    in_valid = 1'b0;
    step();
    check("t1_early", 64'(bus_u.out_valid), 64'd0);
    step();
    check("t1_valid", 64'(bus_u.out_valid), 64'd1);
    check("t1_result", 64'({bus_u.out_sign, bus_u.out_zero, bus_u.out_exp, bus_u.out_mant}),
          64'({1'b0, 1'b0, 8'h7F, 32'h80000000}));
    step();

    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      if (k < 4) in_data = t2_in[k];
      step();
      if (k >= 2) begin
        check("t2_valid", 64'(bus_s.out_valid), 64'd1);
        check("t2_result", 64'({bus_s.out_sign, bus_s.out_zero, bus_s.out_exp, bus_s.out_mant}),
              64'(t2_exp[k-2]));
      end
    end
    step();

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = t3_in[k];
      step();
    end
    out_ready = 1'b0;
    in_data   = 32'h40;
    #1;
    check("t3_first_valid", 64'(bus_s.out_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("t3_stall_ready", 64'(bus_s.in_ready), 64'd0);
      check("t3_stall_occ", 64'(occ_s), 64'd3);
      check("t3_stall_out", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}),
            64'({1'b1, 8'd131, 32'h80000000}));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t3_rel_ready", 64'(bus_s.in_ready), 64'd1);
    check("t3_out0", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}), 64'({1'b1, 8'd131, 32'h80000000}));
    step();
    in_valid = 1'b0;
    check("t3_out1", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}), 64'({1'b1, 8'd132, 32'h80000000}));
    step();
    check("t3_out2", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}), 64'({1'b1, 8'd132, 32'hC0000000}));
    step();
    check("t3_out3", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}), 64'({1'b1, 8'd133, 32'h80000000}));
    step();
    check("t3_empty", 64'(bus_s.out_valid), 64'd0);

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 << k;
      step();
    end
    check("t4_occ_full", 64'(occ_s), 64'd3);
    flush   = 1'b1;
    in_data = 32'hDEAD0000;
    #1;
    check("t4_flush_ready", 64'(bus_s.in_ready), 64'd0);
    step();
    flush = 1'b0;
    check("t4_post_valid", 64'(bus_s.out_valid), 64'd0);
    check("t4_post_occ", 64'(occ_s), 64'd0);
    in_data = 32'h100;
    step();
    in_valid = 1'b0;
    check("t4_gap1", 64'(bus_s.out_valid), 64'd0);
    step();
    check("t4_gap2", 64'(bus_s.out_valid), 64'd0);
    step();
    check("t4_result", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}), 64'({1'b1, 8'd135, 32'h80000000}));
    step();

    in_valid = 1'b1;
    in_data  = 32'h5;
    step();
    in_data  = 32'h6;
    step();
    in_valid = 1'b0;
    check("t5_occ_pre", 64'(occ_s), 64'd2);
    aclr_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus_s.out_valid), 64'd0);
    check("t5_rst_occ", 64'(occ_s), 64'd0);
    check("t5_rst_aclr", 64'(shf_aclr_s), 64'd1);
    check("t5_rst_dist", 64'(shf_dist_s), 64'd0);
    step();
    aclr_n   = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h3;
    step();
    in_valid = 1'b0;
    check("t5_gap1", 64'(bus_s.out_valid), 64'd0);
    step();
    check("t5_gap2", 64'(bus_s.out_valid), 64'd0);
    step();
    check("t5_result", 64'({bus_s.out_valid, bus_s.out_exp, bus_s.out_mant}), 64'({1'b1, 8'd128, 32'hC0000000}));
    step();

    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      case ($urandom_range(0, 5))
        0: in_data = 32'd0;
        1: in_data = 32'h80000000;
        2: in_data = $urandom;
        3, 4: in_data = $urandom >> $urandom_range(0, 31);
        default: begin
          rnd     = $urandom >> $urandom_range(0, 31);
          in_data = 32'd0 - rnd;
        end
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
      cyc++;
    end
    check("rnd_accepts", 64'(n_acc >= 10000), 64'd1);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    check("drain_s", 64'(q_s.size()), 64'd0);
    check("drain_u", 64'(q_u.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
